// File: rtl/la_capture.sv
// rtl/la_capture.sv - logic-analyzer capture engine with trigger, divider and register readout
//
// Purpose:
//   Waits (ARMED) for a masked pattern match on the probe pins at a divided
//   sample rate, then records DEPTH consecutive samples (CAPTURE) into an
//   internal buffer and parks in DONE. The buffer is drained one sample per
//   DATA register read.
//
// Ports:
//   PCI_CLK    in   sole clock, rising edge
//   PCI_RST    in   asynchronous active-high reset
//   PROBE      in   probe pins, already synchronous to PCI_CLK
//   reg_wr     in   one-cycle register write strobe
//   reg_rd     in   one-cycle register read strobe
//   reg_addr   in   dword register index
//   reg_wdata  in   register write data
//   reg_rdata  out  registered read data (one-cycle latency)
//   capturing  out  high in ARMED or CAPTURE
//   done       out  high in DONE
//
// Registers: 0 CTRL (W: bit0 ARM, bit1 ABORT), 1 STATUS (R: [1:0] state,
//   [31:16] count), 2 TRIG ([15:0] value, [31:16] mask), 3 DIV ([15:0]),
//   4 DATA (R: pops one sample, [31] valid).

module la_capture #(
  parameter int DEPTH_LOG2 = 8,
  parameter int PROBE_W    = 16
) (
  input  logic               PCI_CLK,
  input  logic               PCI_RST,
  input  logic [PROBE_W-1:0] PROBE,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               capturing,
  output logic               done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_STATUS = 4'd1;
  localparam logic [3:0] A_TRIG   = 4'd2;
  localparam logic [3:0] A_DIV    = 4'd3;
  localparam logic [3:0] A_DATA   = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     trig_q, trig_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  // The sample count also serves as the write pointer: every write lands at
  // index count, and capture stops once entry DEPTH-1 is written, so the
  // pointer never wraps.
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     rdata_d;

  logic [PROBE_W-1:0] mem [DEPTH];
  logic               mem_we;

  logic        tick;
  logic        trig_hit;
  logic        ctrl_wr;
  logic        arm;
  logic        abort;
  logic        data_avail;
  logic [15:0] probe16;
  logic [15:0] samp16;

  assign probe16 = 16'(PROBE);
  assign samp16  = 16'(mem[rd_ptr_q[DEPTH_LOG2-1:0]]);

  // >= rather than == so that lowering DIV below the running counter ticks
  // at once instead of waiting for the 16-bit counter to wrap.
  assign tick       = (div_cnt_q >= div_q);
  assign trig_hit   = (((probe16 ^ trig_q[15:0]) & trig_q[31:16]) == 16'd0);
  assign data_avail = (rd_ptr_q < cnt_q);

  // ABORT wins over ARM when both bits are set in one write.
  assign ctrl_wr = reg_wr && (reg_addr == A_CTRL);
  assign abort   = ctrl_wr && reg_wdata[1];
  assign arm     = ctrl_wr && reg_wdata[0] && !reg_wdata[1];

  assign capturing = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    trig_d    = trig_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    rdata_d   = reg_rdata;
    mem_we    = 1'b0;

    // Sampling
    if (capturing) begin
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
    end
    case (state_q)
      S_ARMED: begin
        if (tick && trig_hit) begin
          mem_we  = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (tick) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: ;
    endcase

    // Reads see register values from before any same-cycle write.
    if (reg_rd) begin
      case (reg_addr)
        A_STATUS: rdata_d = {16'(cnt_q), 14'd0, state_q};
        A_TRIG:   rdata_d = trig_q;
        A_DIV:    rdata_d = {16'd0, div_q};
        A_DATA: begin
          if ((state_q == S_DONE) && data_avail) begin
            rdata_d  = {1'b1, 15'd0, samp16};
            rd_ptr_d = rd_ptr_q + CW'(1);
          end else begin
            rdata_d = 32'd0;
          end
        end
        default:  rdata_d = 32'd0;
      endcase
    end

    // Writes
    if (reg_wr) begin
      case (reg_addr)
        A_TRIG: trig_d = reg_wdata;
        A_DIV:  div_d  = reg_wdata[15:0];
        default: ;
      endcase
    end
    if (abort) begin
      // Freeze the capture as it stood before this edge.
      state_d   = S_IDLE;
      mem_we    = 1'b0;
      cnt_d     = cnt_q;
      div_cnt_d = div_cnt_q;
    end else if (arm) begin
      state_d   = S_ARMED;
      mem_we    = 1'b0;
      div_cnt_d = 16'd0;
      cnt_d     = '0;
      rd_ptr_d  = '0;
    end
  end

  always_ff @(posedge PCI_CLK or posedge PCI_RST) begin
    if (PCI_RST) begin
      state_q   <= S_IDLE;
      trig_q    <= 32'd0;
      div_q     <= 16'd0;
      div_cnt_q <= 16'd0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      reg_rdata <= 32'd0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      reg_rdata <= rdata_d;
    end
  end

  // Sample buffer: no reset, contents are undefined after reset.
  always_ff @(posedge PCI_CLK) begin
    if (mem_we) begin
      mem[cnt_q[DEPTH_LOG2-1:0]] <= PROBE;
    end
  end

endmodule

// File: tb/tb_la_capture.sv
// tb/tb_la_capture.sv - self-checking bench for la_capture with probe history reference model
module tb_la_capture;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_STATUS = 4'd1;
  localparam logic [3:0] A_TRIG   = 4'd2;
  localparam logic [3:0] A_DIV    = 4'd3;
  localparam logic [3:0] A_DATA   = 4'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] probe = 16'd0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [3:0]  reg_addr = 4'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;
  logic        capturing;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;
  int inc_base = 0;
  int inc_off  = 0;
  bit rnd_mode = 1'b0;

  // Probe value in effect at each clock edge, indexed by edge number.
  logic [15:0] hist [65536];

  always #5 clk = ~clk;

  la_capture #(.DEPTH_LOG2(8), .PROBE_W(16)) dut (
    .PCI_CLK   (clk),
    .PCI_RST   (rst),
    .PROBE     (probe),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .capturing (capturing),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_probe();
    if (rnd_mode) probe = 16'($urandom);
    else          probe = 16'(cyc_n - inc_base + inc_off);
    hist[16'(cyc_n)] = probe;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
    drive_probe();
  endtask

  task automatic set_inc(input int off);
    rnd_mode = 1'b0;
    inc_base = cyc_n;
    inc_off  = off;
    drive_probe();
  endtask

  task automatic set_rnd();
    rnd_mode = 1'b1;
    drive_probe();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    reg_addr = a; reg_rd = 1'b1;
    step();
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  // Reference: after the ARM edge, ticks fall every (d+1) edges; the first
  // tick whose probe matches the trigger starts the capture and the next 255
  // ticks complete it.
  task automatic run_capture(input string tag, input int d, input logic [31:0] trig,
                             input bit rnd, input int off, output logic [31:0] first);
    int arm_idx, t, j0, m_obs;
    bit cap_ok;
    logic [31:0] got;
    logic [15:0] s;
    wr(A_DIV, 32'(d));
    wr(A_TRIG, trig);
    if (rnd) set_rnd(); else set_inc(off);
    arm_idx = cyc_n;
    wr(A_CTRL, 32'h1);
    t = 0;
    cap_ok = 1'b1;
    while (!done && t < 20000) begin
      if (capturing !== 1'b1) cap_ok = 1'b0;
      step();
      t++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " capturing while running"}, 32'(cap_ok), 32'd1);
    check({tag, " capturing in done"}, 32'(capturing), 32'd0);
    m_obs = cyc_n - arm_idx - 1;
    j0 = 0;
    for (int j = 1; arm_idx + (d + 1) * j < cyc_n; j++) begin
      s = hist[16'(arm_idx + (d + 1) * j)];
      if (((s ^ trig[15:0]) & trig[31:16]) == 16'd0) begin
        j0 = j;
        break;
      end
    end
    check({tag, " trigger found"}, 32'(j0 != 0), 32'd1);
    check({tag, " done cycle"}, 32'(m_obs), 32'((d + 1) * (j0 + 255)));
    rd(A_STATUS, got);
    check({tag, " status"}, got, 32'h0100_0003);
    first = 32'd0;
    for (int k = 0; k < 256; k++) begin
      rd(A_DATA, got);
      if (k == 0) first = got;
      check({tag, " data"}, got, {16'h8000, hist[16'(arm_idx + (d + 1) * (j0 + k))]});
    end
    rd(A_DATA, got);
    check({tag, " data empty"}, got, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] first;
    logic [31:0] mask;
    int arm_idx, m, d;

    drive_probe();
    repeat (3) step();
    check("reset capturing", 32'(capturing), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rdata", reg_rdata, 32'd0);
    #2 rst = 1'b0;
    step();
    rd(A_STATUS, got); check("reset status", got, 32'd0);
    rd(A_TRIG, got);   check("reset trig", got, 32'd0);
    rd(A_DIV, got);    check("reset div", got, 32'd0);

    // Register file behaviour
    wr(A_TRIG, 32'hA5A5_0F0F);
    reg_addr = A_TRIG; reg_wdata = 32'h1234_5678; reg_wr = 1'b1; reg_rd = 1'b1;
    step();
    reg_wr = 1'b0; reg_rd = 1'b0;
    check("trig read during write", reg_rdata, 32'hA5A5_0F0F);
    rd(A_TRIG, got);   check("trig readback", got, 32'h1234_5678);
    wr(A_DIV, 32'hFFFF_0007);
    rd(A_DIV, got);    check("div readback", got, 32'h0000_0007);
    wr(4'd9, 32'hFFFF_FFFF);
    rd(4'd9, got);     check("unmapped read", got, 32'd0);
    rd(A_CTRL, got);   check("ctrl read", got, 32'd0);
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd(A_STATUS, got); check("status read-only", got, 32'd0);
    rd(A_DATA, got);   check("data in idle", got, 32'd0);

    // Incrementing probe, every cycle, immediate trigger
    run_capture("inc", 0, 32'h0, 1'b0, -1, first);
    check("inc first sample", first, 32'h8000_0000);

    // Pattern trigger on low byte 0x42 reached 10 cycles after ARM
    run_capture("pattern", 0, 32'h00FF_0042, 1'b0, 32'h38, first);
    check("pattern first low byte", {24'd0, first[7:0]}, 32'h42);

    // Divided sample rate
    run_capture("div3", 3, 32'h0, 1'b0, 0, first);

    // Random probe, random divider, sparse random mask
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(0, 2);
      mask = (32'd1 << $urandom_range(0, 15)) | (32'd1 << $urandom_range(0, 15));
      run_capture("random", d, {mask[15:0], 16'($urandom)}, 1'b1, 0, first);
    end

    // Abort mid-capture
    wr(A_DIV, 32'd0);
    wr(A_TRIG, 32'd0);
    set_inc(0);
    arm_idx = cyc_n;
    wr(A_CTRL, 32'h1);
    repeat (50) step();
    m = cyc_n - arm_idx;
    wr(A_CTRL, 32'h3);
    rd(A_STATUS, got);
    check("abort status", got, {16'(m - 1), 16'h0000});
    check("abort capturing", 32'(capturing), 32'd0);
    check("abort done", 32'(done), 32'd0);
    repeat (5) step();
    rd(A_STATUS, got);
    check("abort status frozen", got, {16'(m - 1), 16'h0000});
    rd(A_DATA, got);
    check("abort data", got, 32'd0);

    // Asynchronous reset mid-capture
    wr(A_DIV, 32'd5);
    wr(A_TRIG, 32'd0);
    arm_idx = cyc_n;
    wr(A_CTRL, 32'h1);
    repeat (40) step();
    m = cyc_n - arm_idx;
    rd(A_STATUS, got);
    check("pre-reset status", got, {16'((m - 1) / 6), 16'h0002});
    check("pre-reset capturing", 32'(capturing), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset capturing", 32'(capturing), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset rdata", reg_rdata, 32'd0);
    step();
    rst = 1'b0;
    rd(A_STATUS, got); check("post-reset status", got, 32'd0);
    rd(A_DIV, got);    check("post-reset div", got, 32'd0);
    rd(A_TRIG, got);   check("post-reset trig", got, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/la_capture.md
LA_CAPTURE -- requirements
Module: la_capture

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving log2 of the sample buffer depth (DEPTH = 2^DEPTH_LOG2).
REQ-002 The block SHALL have parameter PROBE_W, default 16, giving the probe width (1..16).
REQ-003 PCI_CLK  input  1  sole clock; all logic on the rising edge.
REQ-004 PCI_RST  input  1  reset; asynchronous, active-high.
REQ-005 PROBE  input  PROBE_W  logic-analyzer probe pins, already synchronised to PCI_CLK.
REQ-006 reg_wr  input  1  one-cycle write strobe from the PCI IO target (accepted data phase).
REQ-007 reg_rd  input  1  one-cycle read strobe from the PCI IO target.
REQ-008 reg_addr  input  4  dword register index (PCI_AD[5:2] latched by the target).
REQ-009 reg_wdata  input  32  write data.
REQ-010 reg_rdata  output  32  registered read data.
REQ-011 capturing  output  1  high in ARMED or CAPTURE (LED drive).
REQ-012 done  output  1  high in DONE.

Function
REQ-013 Register map SHALL be: 0 CTRL (W bit0 ARM, bit1 ABORT; reads 0); 1 STATUS (R [1:0] state, [31:16] sample count); 2 TRIG (R/W [15:0] value, [31:16] mask); 3 DIV (R/W [15:0] divider); 4 DATA (R, pops one sample: [15:0] sample zero-extended, [31] valid).
REQ-014 Unmapped addresses SHALL read 0; writes to them and to read-only fields SHALL be ignored.
REQ-015 The state machine SHALL have states IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-016 A sample tick SHALL occur when the divider counter equals DIV, then the counter reloads 0; DIV=0 gives a tick every cycle.
REQ-017 A CTRL write with ARM=1, in any state, SHALL clear divider counter, write pointer, read pointer and count, and enter ARMED on the next edge.
REQ-018 A CTRL write with ABORT=1 SHALL enter IDLE, keeping buffer, count and pointers; ABORT SHALL win over ARM in the same write.
REQ-019 In ARMED, on a tick where ((PROBE ^ value) & mask) == 0, the sample SHALL be written at address 0, count becomes 1, state goes CAPTURE; mask=0 triggers on the first tick.
REQ-020 In CAPTURE each tick SHALL write PROBE at the write pointer and increment pointer and count; the tick writing entry DEPTH-1 SHALL also move to DONE on the same edge.
REQ-021 Count SHALL be DEPTH_LOG2+1 bits so DEPTH is representable; write pointer SHALL never wrap.
REQ-022 reg_rdata SHALL be loaded on the edge where reg_rd=1 with the value for reg_addr, and hold otherwise (one-cycle read latency).
REQ-023 A DATA read in DONE with read pointer < count SHALL return {1'b1, sample} and increment the read pointer exactly once per strobe.
REQ-024 A DATA read in DONE with read pointer == count, or in any other state, SHALL return 0 and leave the pointer unchanged.
REQ-025 TRIG/DIV writes during ARMED/CAPTURE SHALL take effect from the next tick.
REQ-026 Simultaneous reg_wr and reg_rd SHALL both be processed; a read of a register being written returns the old value.
REQ-027 The buffer SHALL be a DEPTH x PROBE_W RAM with synchronous write; synchronous read is permitted because reg_rdata is registered.

Reset
REQ-028 On PCI_RST: state IDLE, TRIG=0, DIV=0, counters, pointers and count 0, reg_rdata=0, capturing=0, done=0; buffer contents undefined.
REQ-029 Reset asserted mid-capture SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-030 DIV=0, mask=0, ARM, PROBE incrementing from 0 -> done after 256 cycles, STATUS count 256, DATA reads return 0x80000000..0x800000FF, 257th read returns 0.
REQ-031 TRIG mask=0x00FF, value=0x0042, ARM, PROBE low byte reaches 0x42 at cycle 10 -> first DATA sample has low byte 0x42, capturing=1 until done.
REQ-032 DIV=3, mask=0, ARM -> consecutive samples 4 cycles apart, done after 1024 cycles.
REQ-033 ARM, then CTRL write 0x3 mid-capture -> STATUS state 0, count frozen, DATA reads return 0.
REQ-034 PCI_RST pulsed mid-capture -> all outputs 0 asynchronously, STATUS reads 0 afterwards.
